// File: rtl/prefix_addsub_pipe_pkg.sv
// Shared constants and types for the prefix_addsub_pipe adder/subtractor.
// The ADDSUB_ABS_RESULT_EN build option selects the 4-stage magnitude variant.
package prefix_addsub_pipe_pkg;

  localparam int unsigned ADDSUB_W_DEF    = 24;
  localparam int unsigned ADDSUB_LAT_BASE = 3;
  localparam int unsigned ADDSUB_LAT_ABS  = 4;

  // Generate/propagate pair used throughout the prefix tree
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage

// File: rtl/prefix_addsub_pipe_prefix_cell.sv
// Kogge-Stone combine node: merges a high group with the adjacent low group.
module prefix_cell
  import prefix_addsub_pipe_pkg::*;
(
  input  gp_t hi_i,
  input  gp_t lo_i,
  output gp_t gp_o
);

  // (G,P) = (Gh | Ph&Gl, Ph&Pl)
  always_comb begin
    gp_o.g = hi_i.g | (hi_i.p & lo_i.g);
    gp_o.p = hi_i.p & lo_i.p;
  end

endmodule

// File: rtl/prefix_addsub_pipe.sv
// Pipelined unsigned add/subtract with a Kogge-Stone carry tree.
// Stage 1: bitwise g/p, stage 2: prefix carries, stage 3: sum/flags.
// Define ADDSUB_ABS_RESULT_EN to add a 4th stage that outputs |A-B| for
// subtractions with A < B; flags are the same in both builds.
module prefix_addsub_pipe
  import prefix_addsub_pipe_pkg::*;
#(
  parameter int unsigned W = ADDSUB_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_cout,
  output logic         out_sign
);

  // Prefix tree depth covering W bit positions plus the carry-in slot
  localparam int unsigned LVLS = $clog2(W + 1);

  logic         adv_c;
  logic [W-1:0] b_x;

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_g_q, s1_g_d;
  logic [W-1:0] s1_p_q, s1_p_d;
  logic         s1_cin_q, s1_cin_d;
  logic         s1_sub_q, s1_sub_d;

  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_carry_q, s2_carry_d;
  logic [W-1:0] s2_p_q, s2_p_d;
  logic         s2_cin_q, s2_cin_d;
  logic         s2_sub_q, s2_sub_d;

  logic         s3_valid_q, s3_valid_d;
  logic [W-1:0] s3_res_q, s3_res_d;
  logic         s3_cout_q, s3_cout_d;
  logic         s3_sign_q, s3_sign_d;

`ifdef ADDSUB_ABS_RESULT_EN
  logic         s4_valid_q, s4_valid_d;
  logic [W-1:0] s4_res_q, s4_res_d;
  logic         s4_cout_q, s4_cout_d;
  logic         s4_sign_q, s4_sign_d;
`endif

  logic [W-1:0] carry_c;
  logic         cin_fin_c;
  logic [W:0]   fin_p_unused;

  // One global advance: every stage moves together or holds together
  assign adv_c    = !out_valid | out_ready;
  assign in_ready = adv_c;
  assign b_x      = in_sub ? ~in_b : in_b;

  // Kogge-Stone tree; slot 0 carries cin as a generate, slot i+1 is bit i
  for (genvar l = 0; l <= int'(LVLS); l++) begin : g_lvl
    gp_t [W:0] node;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i <= int'(W); i++) begin : g_bit
        if (i == 0) begin : g_cin
          assign node[i] = {s1_cin_q, 1'b0};
        end else begin : g_op
          assign node[i] = {s1_g_q[i-1], s1_p_q[i-1]};
        end
      end
    end else begin : g_comb
      localparam int D = 1 << (l - 1);
      for (genvar i = 0; i <= int'(W); i++) begin : g_bit
        if (i >= D) begin : g_cell
          prefix_cell u_cell (
            .hi_i (g_lvl[l-1].node[i]),
            .lo_i (g_lvl[l-1].node[i-D]),
            .gp_o (node[i])
          );
        end else begin : g_pass
          assign node[i] = g_lvl[l-1].node[i];
        end
      end
    end
  end

  // carry_c[i] is the carry out of bit i; group propagates are not needed
  for (genvar i = 0; i <= int'(W); i++) begin : g_fin
    assign fin_p_unused[i] = g_lvl[LVLS].node[i].p;
    if (i == 0) begin : g_cin
      assign cin_fin_c = g_lvl[LVLS].node[i].g;
    end else begin : g_carry
      assign carry_c[i-1] = g_lvl[LVLS].node[i].g;
    end
  end

  // Next-state for all stages: hold by default, shift on advance
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    s1_cin_d   = s1_cin_q;
    s1_sub_d   = s1_sub_q;
    s2_valid_d = s2_valid_q;
    s2_carry_d = s2_carry_q;
    s2_p_d     = s2_p_q;
    s2_cin_d   = s2_cin_q;
    s2_sub_d   = s2_sub_q;
    s3_valid_d = s3_valid_q;
    s3_res_d   = s3_res_q;
    s3_cout_d  = s3_cout_q;
    s3_sign_d  = s3_sign_q;
`ifdef ADDSUB_ABS_RESULT_EN
    s4_valid_d = s4_valid_q;
    s4_res_d   = s4_res_q;
    s4_cout_d  = s4_cout_q;
    s4_sign_d  = s4_sign_q;
`endif
    if (adv_c) begin
      s1_valid_d = in_valid;
      s1_g_d     = in_a & b_x;
      s1_p_d     = in_a ^ b_x;
      s1_cin_d   = in_sub;
      s1_sub_d   = in_sub;
      s2_valid_d = s1_valid_q;
      s2_carry_d = carry_c;
      s2_p_d     = s1_p_q;
      s2_cin_d   = cin_fin_c;
      s2_sub_d   = s1_sub_q;
      s3_valid_d = s2_valid_q;
      s3_res_d   = s2_p_q ^ {s2_carry_q[W-2:0], s2_cin_q};
      s3_cout_d  = s2_carry_q[W-1];
      s3_sign_d  = s2_sub_q & ~s2_carry_q[W-1];
`ifdef ADDSUB_ABS_RESULT_EN
      s4_valid_d = s3_valid_q;
      s4_res_d   = s3_sign_q ? -s3_res_q : s3_res_q;
      s4_cout_d  = s3_cout_q;
      s4_sign_d  = s3_sign_q;
`endif
    end
  end

  // Stage registers; reset drops every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_sub_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_carry_q <= '0;
      s2_p_q     <= '0;
      s2_cin_q   <= 1'b0;
      s2_sub_q   <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_res_q   <= '0;
      s3_cout_q  <= 1'b0;
      s3_sign_q  <= 1'b0;
`ifdef ADDSUB_ABS_RESULT_EN
      s4_valid_q <= 1'b0;
      s4_res_q   <= '0;
      s4_cout_q  <= 1'b0;
      s4_sign_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_g_q     <= s1_g_d;
      s1_p_q     <= s1_p_d;
      s1_cin_q   <= s1_cin_d;
      s1_sub_q   <= s1_sub_d;
      s2_valid_q <= s2_valid_d;
      s2_carry_q <= s2_carry_d;
      s2_p_q     <= s2_p_d;
      s2_cin_q   <= s2_cin_d;
      s2_sub_q   <= s2_sub_d;
      s3_valid_q <= s3_valid_d;
      s3_res_q   <= s3_res_d;
      s3_cout_q  <= s3_cout_d;
      s3_sign_q  <= s3_sign_d;
`ifdef ADDSUB_ABS_RESULT_EN
      s4_valid_q <= s4_valid_d;
      s4_res_q   <= s4_res_d;
      s4_cout_q  <= s4_cout_d;
      s4_sign_q  <= s4_sign_d;
`endif
    end
  end

`ifdef ADDSUB_ABS_RESULT_EN
  assign out_valid = s4_valid_q;
  assign out_res   = s4_res_q;
  assign out_cout  = s4_cout_q;
  assign out_sign  = s4_sign_q;
`else
  assign out_valid = s3_valid_q;
  assign out_res   = s3_res_q;
  assign out_cout  = s3_cout_q;
  assign out_sign  = s3_sign_q;
`endif

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Self-checking bench for prefix_addsub_pipe (either ADDSUB_ABS_RESULT_EN build).
module tb_prefix_addsub_pipe;
  import prefix_addsub_pipe_pkg::*;

  localparam int unsigned TW = 24;
`ifdef ADDSUB_ABS_RESULT_EN
  localparam int unsigned LAT = ADDSUB_LAT_ABS;
  localparam logic [TW-1:0] R_3M5 = 24'h000002;
  localparam logic [TW-1:0] R_0M1 = 24'h000001;
`else
  localparam int unsigned LAT = ADDSUB_LAT_BASE;
  localparam logic [TW-1:0] R_3M5 = 24'hFFFFFE;
  localparam logic [TW-1:0] R_0M1 = 24'hFFFFFF;
`endif

  typedef struct packed {
    logic [TW-1:0] res;
    logic          cout;
    logic          sign;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_sub;
  logic          out_valid, out_ready, out_cout, out_sign;
  logic [TW-1:0] in_a, in_b, out_res;

  exp_t        q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned n_out = 0;
  int unsigned first_out_cyc = 0;
  int unsigned last_out_cyc = 0;

  always #5 clk = ~clk;

  prefix_addsub_pipe #(.W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_cout  (out_cout),
    .out_sign  (out_sign)
  );

  // Reference: plain integer arithmetic on unbounded-width values
  function automatic exp_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                 input logic sub);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned m  = 64'd1 << TW;
    longint unsigned s;
    exp_t e;
    if (!sub) begin
      s      = ua + ub;
      e.res  = TW'(s % m);
      e.cout = (s >= m);
      e.sign = 1'b0;
    end else begin
      e.cout = (ua >= ub);
      e.sign = (ua < ub);
`ifdef ADDSUB_ABS_RESULT_EN
      e.res  = TW'((ua >= ub) ? (ua - ub) : (ub - ua));
`else
      e.res  = TW'((ua + m - ub) % m);
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: account transfers before the edge, return 1 time unit after it
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_res", 32'(out_res), 32'(e.res));
          chk("sb_cout", 32'(out_cout), 32'(e.cout));
          chk("sb_sign", 32'(out_sign), 32'(e.sign));
        end
        if (n_out == 0) first_out_cyc = cyc;
        n_out++;
        last_out_cyc = cyc;
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Single beat into an idle pipe: latency plus the exact directed result
  task automatic run_one(input string tag, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic sub, input logic [TW-1:0] er, input logic ec,
                         input logic es);
    int unsigned n;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_res"}, 32'(out_res), 32'(er));
    chk({tag, "_cout"}, 32'(out_cout), 32'(ec));
    chk({tag, "_sign"}, 32'(out_sign), 32'(es));
    tick();
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [TW-1:0] snap_res;
    logic          snap_cout, snap_sign, hold;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("rst_out_sign", 32'(out_sign), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_one("add_wrap", 24'h000001, 24'hFFFFFF, 1'b0, 24'h000000, 1'b1, 1'b0);
    run_one("sub_5m3", 24'd5, 24'd3, 1'b1, 24'd2, 1'b1, 1'b0);
    run_one("sub_3m5", 24'd3, 24'd5, 1'b1, R_3M5, 1'b0, 1'b1);
    run_one("sub_eq", 24'hABCDEF, 24'hABCDEF, 1'b1, 24'h000000, 1'b1, 1'b0);
    run_one("add_max", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'hFFFFFE, 1'b1, 1'b0);
    run_one("add_zero", 24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0);
    run_one("sub_0m1", 24'h000000, 24'h000001, 1'b1, R_0M1, 1'b0, 1'b1);

    // 100 back-to-back random beats at full rate
    n_out = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_a = TW'($urandom); in_b = TW'($urandom); in_sub = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    drain("b2b");
    chk("b2b_count", 32'(n_out), 32'd100);
    chk("b2b_rate", 32'(last_out_cyc - first_out_cyc), 32'd99);

    // Fill the pipe against a stalled sink, then hold for 5 cycles
    out_ready = 1'b0;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      in_a = TW'($urandom); in_b = TW'($urandom); in_sub = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    snap_res = out_res; snap_cout = out_cout; snap_sign = out_sign;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_res", 32'(out_res), 32'(snap_res));
      chk("stall_cout", 32'(out_cout), 32'(snap_cout));
      chk("stall_sign", 32'(out_sign), 32'(snap_sign));
      in_a = TW'($urandom); in_b = TW'($urandom); in_sub = 1'($urandom);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = TW'($urandom); in_b = TW'($urandom); in_sub = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    drain("stall");

    // Random valid/ready on both sides; held outputs must not move
    for (int i = 0; i < 200; i++) begin
      in_a = TW'($urandom); in_b = TW'($urandom); in_sub = 1'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      hold = out_valid && !out_ready;
      snap_res = out_res; snap_cout = out_cout; snap_sign = out_sign;
      tick();
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_res", 32'(out_res), 32'(snap_res));
        chk("hold_flags", 32'({out_cout, out_sign}), 32'({snap_cout, snap_sign}));
      end
    end
    drain("rand");

    // Reset with three beats in flight: none may ever come out
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = TW'($urandom); in_b = TW'($urandom); in_sub = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_res", 32'(out_res), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("mid_rst_no_emerge", 32'(out_valid), 32'd0);
      tick();
    end

    run_one("post_rst", 24'd7, 24'd2, 1'b1, 24'd5, 1'b1, 1'b0);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
